// File: rtl/case3_pattern_tester.sv
// case3_pattern_tester: exhaustive 128-vector self-test driver for case3.
// Define CASE3_TESTER_CHECK_EN to add the golden-model cross-check.
module case3_pattern_tester #(
  parameter int         RESP_LAT = 1,
  parameter logic [7:0] EXP_X    = 8'd4,
  parameter logic [7:0] EXP_Y    = 8'd120,
  parameter logic [7:0] EXP_Z    = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [6:0] vec,
  input  logic [2:0] resp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] cnt_x,
  output logic [7:0] cnt_y,
  output logic [7:0] cnt_z
`ifdef CASE3_TESTER_CHECK_EN
  ,
  output logic [7:0] mis_cnt,
  output logic [6:0] first_fail
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [6:0]          vec_n;
  logic                accept;
  logic                launch;
  logic                sample;
  logic                fin;
  logic                match;
  logic [RESP_LAT-1:0] tag;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign launch = accept || (state == RUN);
  assign sample = tag[RESP_LAT-1];
  assign fin    = (state == DRAIN) && (tag == '0);
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);

  always_comb begin
    state_n = state;
    vec_n   = vec;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_n = RUN;
          vec_n   = '0;
        end
      end
      RUN: begin
        vec_n = vec + 7'd1;
        if (vec == 7'd126) state_n = DRAIN;
      end
      DRAIN: begin
        if (tag == '0) state_n = DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec   <= '0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
    end
  end

  // tag[k] set means a vector was launched k+1 edges ago
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag[0] <= launch;
      for (int i = 1; i < RESP_LAT; i++) tag[i] <= tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x <= '0;
      cnt_y <= '0;
      cnt_z <= '0;
    end else if (accept) begin
      cnt_x <= '0;
      cnt_y <= '0;
      cnt_z <= '0;
    end else if (sample) begin
      cnt_x <= cnt_x + {7'd0, resp[2]};
      cnt_y <= cnt_y + {7'd0, resp[1]};
      cnt_z <= cnt_z + {7'd0, resp[0]};
    end
  end

`ifdef CASE3_TESTER_CHECK_EN
  logic [6:0] vpipe [RESP_LAT];
  logic [6:0] sv;
  logic [2:0] gold;
  logic       a, b, c, d, e, f, g, eg;

  assign sv = vpipe[RESP_LAT-1];
  assign {a, b, c, d, e, f, g} = sv;
  assign eg = e & g;
  assign gold[2] = a & b & c & d & e;
  assign gold[1] = b | c | (d ^ f) | (e ^ g);
  assign gold[0] = d ? ((eg | ~c) & ~(eg & a & b))
                     : ((c & ~eg) | (a & b & eg));

  // vpipe tracks the launched vector alongside its tag bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_LAT; i++) vpipe[i] <= '0;
    end else begin
      vpipe[0] <= vec_n;
      for (int i = 1; i < RESP_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt    <= '0;
      first_fail <= '0;
    end else if (accept) begin
      mis_cnt    <= '0;
      first_fail <= '0;
    end else if (sample && (gold != resp)) begin
      mis_cnt <= mis_cnt + 8'd1;
      if (mis_cnt == 8'd0) first_fail <= sv;
    end
  end

  assign match = (cnt_x == EXP_X) && (cnt_y == EXP_Y) &&
                 (cnt_z == EXP_Z) && (mis_cnt == 8'd0);
`else
  assign match = (cnt_x == EXP_X) && (cnt_y == EXP_Y) &&
                 (cnt_z == EXP_Z);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (accept) begin
      pass <= 1'b0;
    end else if (fin) begin
      pass <= match;
    end
  end

endmodule
